imm_decode_stage: RTL
=====================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter N, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter RESET_PC_TAG, default 0, value loaded into the out_pc register on reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have port in_valid, input, 1, upstream has an instruction.
REQ-007 SHALL have port in_ready, output, 1, stage can accept an instruction this cycle.
REQ-008 SHALL have port in_instr, input, 32, raw RV32 instruction word.
REQ-009 SHALL have port in_pc, input, N, address of in_instr.
REQ-010 SHALL have port out_valid, output, 1, out_* fields hold a decoded entry.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the entry.
REQ-012 SHALL have port out_imm, output, N, decoded immediate.
REQ-013 SHALL have port out_type, output, 3, format code: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
REQ-014 SHALL have port out_target, output, N, out_pc + out_imm modulo 2^N.
REQ-015 SHALL have port out_pc, output, N, pc of the entry.
REQ-016 SHALL have port out_illegal, output, 1, opcode not in the decode table.

Function
REQ-017 SHALL decode by in_instr[6:0]: 0010011, 0000011, 1100111, 1110011, 0001111 as I; 0100011 as S; 1100011 as B; 0110111, 0010111 as U; 1101111 as J; 0110011 as R; all others as illegal.
REQ-018 I: imm = sext(instr[31:20]); S: imm = sext({instr[31:25], instr[11:7]}).
REQ-019 B: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); J: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-020 U: imm = sext({instr[31:12], 12'b0}) to N bits; R and illegal: imm = 0.
REQ-021 Every sign extension SHALL replicate instr[31] to bit N-1.
REQ-022 out_target SHALL be computed for every type; it is an N-bit add and the carry is dropped.
REQ-023 Decode and add SHALL occur before registering, so an accepted input appears on out_* the next cycle (latency 1).
REQ-024 The stage SHALL be a 2-entry skid buffer with states EMPTY, ONE and FULL, counting entries held.
REQ-025 A handshake SHALL occur when valid and ready are both high in the same cycle.
REQ-026 in_ready SHALL equal (state != FULL) and SHALL be a registered signal.
REQ-027 out_valid SHALL equal (state != EMPTY).
REQ-028 Transitions: EMPTY->ONE on input handshake.
REQ-029 ONE->FULL on input handshake without output handshake.
REQ-030 ONE->EMPTY on output handshake without input handshake.
REQ-031 ONE->ONE on both handshakes, with the output register reloaded from the input.
REQ-032 FULL->ONE on output handshake, with the skid entry moved to the output register.
REQ-033 No input handshake SHALL be possible in FULL.
REQ-034 Entries SHALL leave in arrival order; while out_valid=1 and out_ready=0, out_* SHALL be held stable.
REQ-035 flush SHALL force state EMPTY next cycle and drop any in_valid of the same cycle; flush has priority over both handshakes.
REQ-036 in_ready SHALL be 1 in the cycle after a flush.

Reset
REQ-037 On rst=1 at a clock edge: state=EMPTY, out_valid=0, in_ready=1.
REQ-038 On rst=1 at a clock edge: out_imm=0, out_target=0, out_type=0, out_illegal=0, out_pc=RESET_PC_TAG.
REQ-039 rst SHALL override flush and handshakes.
REQ-040 Reset mid-transfer SHALL discard both entries.

Verification
REQ-041 Scenario 1: in_instr=0xFE000CE3 (BEQ), in_pc=0x100 -> next cycle out_imm=0xFFFFFFF8, out_type=3, out_target=0x000000F8.
REQ-042 Scenario 2: in_instr=0x123450B7 (LUI) -> out_imm=0x12345000, out_type=4; with N=64 in_instr=0x800000B7 -> out_imm=0xFFFFFFFF80000000.
REQ-043 Scenario 3: in_instr=0x0010006F (JAL +2048), in_pc=0x1000 -> out_imm=0x800, out_type=5, out_target=0x1800.
REQ-044 Scenario 4: in_instr=0x0000007F -> out_illegal=1, out_type=7, out_imm=0; in_pc=0xFFFFFFFC with imm=8 -> out_target=0x4 (wrap).
REQ-045 Scenario 5: out_ready=0 and three back-to-back inputs A, B, C -> A and B accepted, in_ready=0 from the cycle after B; with out_ready=1, A then B leave and C is accepted.
REQ-046 Scenario 6: state FULL, flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1, and no entry emerges afterward.

Source files
------------

// File: rtl/imm_decode_stage.sv
// RV32 immediate decode stage: decodes format, immediate and branch/jump target,
// then holds results in a 2-entry skid buffer with a registered in_ready.
module imm_decode_stage #(
  parameter int              N            = 32,
  parameter logic [N-1:0]    RESET_PC_TAG = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_instr,
  input  logic [N-1:0] in_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_imm,
  output logic [2:0]   out_type,
  output logic [N-1:0] out_target,
  output logic [N-1:0] out_pc,
  output logic         out_illegal
);

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_ILL = 3'd7;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [N-1:0] imm;
    logic [2:0]   typ;
    logic [N-1:0] target;
    logic [N-1:0] pc;
    logic         illegal;
  } entry_t;

  logic [2:0]   w_type;
  logic [31:0]  w_imm32;
  logic [N-1:0] w_imm;
  entry_t       w_entry;

  // Immediates are assembled at 32 bits; the signed cast extends instr[31] to bit N-1.
  always_comb begin
    w_type  = T_ILL;
    w_imm32 = '0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        w_type  = T_I;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        w_type  = T_S;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        w_type  = T_B;
        w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_type  = T_U;
        w_imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        w_type  = T_J;
        w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        w_type  = T_R;
        w_imm32 = '0;
      end
      default: begin
        w_type  = T_ILL;
        w_imm32 = '0;
      end
    endcase
  end

  assign w_imm = N'($signed(w_imm32));

  always_comb begin
    w_entry.imm     = w_imm;
    w_entry.typ     = w_type;
    w_entry.target  = in_pc + w_imm;
    w_entry.pc      = in_pc;
    w_entry.illegal = (w_type == T_ILL);
  end

  state_t r_state;
  state_t w_state_next;
  logic   r_in_ready;
  entry_t r_out;
  entry_t r_skid;
  logic   w_in_hs;
  logic   w_out_hs;
  logic   w_load_out_in;
  logic   w_load_out_skid;
  logic   w_load_skid;

  assign w_in_hs  = in_valid & r_in_ready;
  assign w_out_hs = out_ready & (r_state != EMPTY);

  always_comb begin
    w_state_next    = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_hs) begin
            w_state_next  = ONE;
            w_load_out_in = 1'b1;
          end
        end
        ONE: begin
          if (w_in_hs && w_out_hs) begin
            w_load_out_in = 1'b1;
          end else if (w_in_hs) begin
            w_state_next = FULL;
            w_load_skid  = 1'b1;
          end else if (w_out_hs) begin
            w_state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (w_out_hs) begin
            w_state_next    = ONE;
            w_load_out_skid = 1'b1;
          end
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_out      <= '{imm: '0, typ: 3'd0, target: '0, pc: RESET_PC_TAG, illegal: 1'b0};
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != FULL);
      if (w_load_out_in) begin
        r_out <= w_entry;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_entry;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != EMPTY);
  assign out_imm     = r_out.imm;
  assign out_type    = r_out.typ;
  assign out_target  = r_out.target;
  assign out_pc      = r_out.pc;
  assign out_illegal = r_out.illegal;

endmodule
